gpu_readback: RTL

//  Memory-mapped VRAM read port for the CPU bus; companion to the VRAM write path.
//  CPU writes a VRAM word address, then reads a data register repeatedly. Each read

---
 rtl/gpu_bus_pkg.sv | 25 ++
 rtl/bus_edge_detect.sv | 26 ++
 rtl/gpu_readback.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gpu_bus_pkg.sv
//------------------------------------------------------------------------------
// Module  : gpu_bus_pkg
// Brief   : Shared register map, STAT bit indices and readback FSM states.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gpu_bus_pkg;

  localparam logic [15:0] REG_PTR  = 16'd0;
  localparam logic [15:0] REG_DATA = 16'd2;
  localparam logic [15:0] REG_STAT = 16'd4;

  localparam int STAT_READY    = 0;
  localparam int STAT_UNDERRUN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rb_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_edge_detect.sv
//------------------------------------------------------------------------------
// Module  : bus_edge_detect
// Brief   : Turns a bus access level into a single-cycle rising-edge pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= level;
  end

  assign pulse = level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/gpu_readback.sv
//------------------------------------------------------------------------------
// Module  : gpu_readback
// Brief   : CPU-bus VRAM read port with pointer, prefetched DATA and STAT regs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpu_readback
  import gpu_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hff08,
  parameter int          VRAM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_write,
  input  logic        cpu_read,
  output logic [15:0] cpu_rdata,
  output logic [15:0] vram_rd_addr,
  output logic        vram_rd_en,
  input  logic [15:0] vram_rd_data
);

  localparam logic [15:0] c_addr_ptr  = BASE_ADDR + REG_PTR;
  localparam logic [15:0] c_addr_data = BASE_ADDR + REG_DATA;
  localparam logic [15:0] c_addr_stat = BASE_ADDR + REG_STAT;
  localparam int          c_cnt_w     = (VRAM_LATENCY > 1) ? $clog2(VRAM_LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(VRAM_LATENCY - 1);

  logic               w_wr_edge;
  logic               w_rd_edge;
  logic               w_ptr_wr;
  logic               w_data_rd;
  logic               w_stat_rd;
  logic               w_start_fetch;
  logic               w_capture;
  rb_state_t          r_state;
  rb_state_t          w_next_state;
  logic [15:0]        r_ptr;
  logic [15:0]        r_data;
  logic               r_ready;
  logic               r_underrun;
  logic [c_cnt_w-1:0] r_cnt;
  logic [15:0]        r_rd_addr;
  logic               r_en_q;

  bus_edge_detect u_wr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (cpu_write),
    .pulse (w_wr_edge)
  );

  bus_edge_detect u_rd_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (cpu_read),
    .pulse (w_rd_edge)
  );

  assign w_ptr_wr  = w_wr_edge && (cpu_addr == c_addr_ptr);
  assign w_data_rd = w_rd_edge && !w_ptr_wr && (cpu_addr == c_addr_data);
  assign w_stat_rd = w_rd_edge && !w_ptr_wr && (cpu_addr == c_addr_stat);

  assign w_start_fetch = w_data_rd && r_ready && (r_state == IDLE);
  assign w_capture     = (r_state == WAIT) && (r_cnt == '0) && !w_ptr_wr;

  // An abort during the strobe cycle must not produce back-to-back strobes,
  // so ISSUE waits out one cycle when the previous cycle already strobed.
  assign vram_rd_en   = (r_state == ISSUE) && !r_en_q;
  assign vram_rd_addr = r_rd_addr;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_fetch) w_next_state = ISSUE;
      ISSUE:   if (vram_rd_en)    w_next_state = WAIT;
      WAIT:    if (w_capture)     w_next_state = IDLE;
      default:                    w_next_state = IDLE;
    endcase
    if (w_ptr_wr) w_next_state = ISSUE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 16'd0;
      r_data     <= 16'd0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_cnt      <= '0;
      r_rd_addr  <= 16'd0;
      r_en_q     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_en_q  <= vram_rd_en;

      if (vram_rd_en)
        r_cnt <= c_cnt_load;
      else if ((r_state == WAIT) && (r_cnt != '0))
        r_cnt <= r_cnt - c_cnt_w'(1);

      if (w_ptr_wr) begin
        r_ptr     <= cpu_wdata;
        r_rd_addr <= cpu_wdata;
        r_ready   <= 1'b0;
      end else if (w_capture) begin
        r_data  <= vram_rd_data;
        r_ptr   <= r_ptr + 16'd1;
        r_ready <= 1'b1;
      end else if (w_start_fetch) begin
        r_ready   <= 1'b0;
        r_rd_addr <= r_ptr;
      end

      if (w_data_rd && !r_ready)
        r_underrun <= 1'b1;
      else if (w_stat_rd)
        r_underrun <= 1'b0;
    end
  end

  always_comb begin
    cpu_rdata = 16'd0;
    if (cpu_addr == c_addr_data) begin
      cpu_rdata = r_data;
    end else if (cpu_addr == c_addr_stat) begin
      cpu_rdata[STAT_READY]    = r_ready;
      cpu_rdata[STAT_UNDERRUN] = r_underrun;
    end
  end

endmodule

`default_nettype wire
